// File: rtl/two_ph_pkg.sv
// Shared definitions for the 2-phase bundled-data bridges: FSM encoding,
// default synchronizer depth and a clog2 helper usable in parameter expressions.
package two_ph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/two_ph_ack_sync.sv
// Multi-flop synchronizer bringing an asynchronous 2-phase ack level into clk.
// Shared by the transmit and receive side bridges.
module two_ph_ack_sync
    import two_ph_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic ack_async,
    output logic ack_sync
);

    logic [SYNC_STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], ack_async};
        end
    end

    assign ack_sync = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/two_ph_sync_tx.sv
// Synchronous valid/ready to 2-phase bundled-data (mousetrap) launch bridge.
// Optional sticky ack timeout enabled by defining TWO_PH_SYNC_TX_TIMEOUT_EN.
module two_ph_sync_tx
    import two_ph_pkg::*;
#(
    parameter int DW             = 8,
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          req,
    output logic [DW-1:0] data_out,
    input  logic          ack,
    output logic          busy,
    output logic          err
);

    localparam int SETUP_W = (clog2(SETUP_CYCLES) < 1) ? 1 : clog2(SETUP_CYCLES);
    localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(SETUP_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("two_ph_sync_tx: SYNC_STAGES must be at least 2");
        end
        if (SETUP_CYCLES < 1) begin : g_bad_setup
            $error("two_ph_sync_tx: SETUP_CYCLES must be at least 1");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("two_ph_sync_tx: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    tx_state_t            state_reg, state_next;
    logic [SETUP_W-1:0]   setup_cnt_reg, setup_cnt_next;
    logic                 req_reg, req_next;
    logic [DW-1:0]        data_reg, data_next;
    logic                 ack_s;
    logic                 idle_state;
    logic                 busy_state;

    two_ph_ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk       (clk),
        .rst       (rst),
        .ack_async (ack),
        .ack_sync  (ack_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            setup_cnt_reg <= '0;
            req_reg       <= 1'b0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            setup_cnt_reg <= setup_cnt_next;
            req_reg       <= req_next;
            data_reg      <= data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        setup_cnt_next = setup_cnt_reg;
        req_next       = req_reg;
        data_next      = data_reg;
        idle_state     = 1'b0;
        busy_state     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                idle_state = 1'b1;
                if (in_valid) begin
                    data_next      = in_data;
                    setup_cnt_next = SETUP_LOAD;
                    state_next     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                busy_state = 1'b1;
                if (setup_cnt_reg == '0) begin
                    req_next   = ~req_reg;
                    state_next = ST_WAIT;
                end else begin
                    setup_cnt_next = setup_cnt_reg - 1'b1;
                end
            end
            ST_WAIT: begin
                busy_state = 1'b1;
                // Pipeline has consumed the token once the ack phase catches up.
                if (ack_s == req_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Ready depends only on state (and reset), never on in_valid.
    assign in_ready = idle_state & ~rst;
    assign busy     = busy_state & ~rst;
    assign req      = req_reg;
    assign data_out = data_reg;

`ifdef TWO_PH_SYNC_TX_TIMEOUT_EN
    localparam int TO_W = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_reg;
    logic            err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else if (state_reg == ST_SETUP && state_next == ST_WAIT) begin
            to_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT && to_cnt_reg != TO_MAX) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            // err rises on the same edge the count reaches the limit.
            if (to_cnt_reg == TO_MAX - 1'b1) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule
